// File: rtl/gf2mz_mul_engine_pkg.sv
// rtl/gf2mz_mul_engine_pkg.sv - shared FSM encoding and digit slice helper for the GF(2^M)[z] multiplier
package gf2mz_mul_engine_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CRD,
        S_ISSUE,
        S_START,
        S_WAIT,
        S_ACC,
        S_WR,
        S_DONE
    } state_t;

    // Digit 0 sits in the most significant M bits of a memory word.
    function automatic int digit_hi(input int t, input int d, input int m);
        return (d - t) * m - 1;
    endfunction

endpackage

// File: rtl/gf2m_mul.sv
// rtl/gf2m_mul.sv - GF(2^M) multiplier, operands captured on start, done MUL_LAT cycles later
module gf2m_mul #(
    parameter int          M       = 67,
    parameter int          MUL_LAT = 6,
    parameter logic [M-1:0] POLY   = 'h27
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic [M-1:0] p,
    output logic         done
);

    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    logic [M-1:0]  prod_c;
    logic [CW-1:0] cnt;
    logic          run;

    // MSB-first shift-and-add; POLY holds the reduction terms below z^M.
    always_comb begin
        prod_c = '0;
        for (int n = M - 1; n >= 0; n--) begin
            prod_c = {prod_c[M-2:0], 1'b0} ^ (prod_c[M-1] ? POLY : '0);
            if (b[n]) prod_c = prod_c ^ a;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p   <= '0;
            run <= 1'b0;
            cnt <= '0;
        end else if (start) begin
            p   <= prod_c;
            run <= 1'b1;
            cnt <= CW'(MUL_LAT - 1);
        end else if (run) begin
            if (cnt == '0) run <= 1'b0;
            else           cnt <= cnt - 1'b1;
        end
    end

    assign done = run && (cnt == '0);

endmodule

// File: rtl/gf2mz_digit_fold.sv
// rtl/gf2mz_digit_fold.sv - folds D x D digit products into low/high product words
module gf2mz_digit_fold
    import gf2mz_mul_engine_pkg::*;
#(
    parameter int M = 67,
    parameter int D = 5
) (
    input  logic [D*D*M-1:0] prod,
    output logic [M*D-1:0]   lo,
    output logic [M*D-1:0]   hi
);

    // Product a*D+b lands in slot a+b; slots past D-1 spill into the next C word.
    always_comb begin
        lo = '0;
        hi = '0;
        for (int a = 0; a < D; a++) begin
            for (int b = 0; b < D; b++) begin
                if (a + b < D)
                    lo[digit_hi(a + b, D, M) -: M] ^= prod[(a*D+b)*M +: M];
                else
                    hi[digit_hi(a + b - D, D, M) -: M] ^= prod[(a*D+b)*M +: M];
            end
        end
    end

endmodule

// File: rtl/gf2mz_mul_engine.sv
// rtl/gf2mz_mul_engine.sv - product-scanning GF(2^M)[z] multiplier over D-digit RAM words
module gf2mz_mul_engine
    import gf2mz_mul_engine_pkg::*;
#(
    parameter int           N          = 83,
    parameter int           M          = 67,
    parameter int           D          = 5,
    parameter int           MUL_LAT    = 6,
    parameter logic [M-1:0] FIELD_POLY = 'h27,
    localparam int          WIDTH      = M * D,
    localparam int          DEPTH      = (N + D - 1) / D,
    localparam int          AW         = $clog2(2 * DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             acc_mode,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    A_addr,
    input  logic [WIDTH-1:0] A_di,
    output logic [AW-1:0]    B_addr,
    input  logic [WIDTH-1:0] B_di,
    output logic [AW-1:0]    C_raddr,
    input  logic [WIDTH-1:0] C_di,
    output logic [AW-1:0]    C_waddr,
    output logic             C_we,
    output logic [WIDTH-1:0] C_do
);

    localparam logic [AW-1:0] LAST_K = AW'(2 * DEPTH - 1);
    localparam logic [AW-1:0] MAX_I  = AW'(DEPTH - 1);

    state_t             state;
    logic [AW-1:0]      k, i;
    logic               acc;
    logic [WIDTH-1:0]   lo, hi, carry;
    logic [D*D*M-1:0]   prod;
    logic [D*D-1:0]     mul_done;
    logic [WIDTH-1:0]   fold_lo, fold_hi;
    logic [AW-1:0]      i_lo, i_hi, i_nxt;
    logic               mul_start;

    // Valid A word index range for the current C word k.
    assign i_lo      = (k > MAX_I) ? k - MAX_I : '0;
    assign i_hi      = (k > MAX_I) ? MAX_I : k;
    assign i_nxt     = i + 1'b1;
    assign mul_start = (state == S_START);

    for (genvar ga = 0; ga < D; ga++) begin : g_row
        for (genvar gb = 0; gb < D; gb++) begin : g_col
            gf2m_mul #(
                .M       (M),
                .MUL_LAT (MUL_LAT),
                .POLY    (FIELD_POLY)
            ) u_mul (
                .clk   (clk),
                .rst   (rst),
                .start (mul_start),
                .a     (A_di[digit_hi(ga, D, M) -: M]),
                .b     (B_di[digit_hi(gb, D, M) -: M]),
                .p     (prod[(ga*D+gb)*M +: M]),
                .done  (mul_done[ga*D+gb])
            );
        end
    end

    gf2mz_digit_fold #(.M(M), .D(D)) u_fold (
        .prod (prod),
        .lo   (fold_lo),
        .hi   (fold_hi)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            C_we    <= 1'b0;
            C_do    <= '0;
            A_addr  <= '0;
            B_addr  <= '0;
            C_raddr <= '0;
            C_waddr <= '0;
            k       <= '0;
            i       <= '0;
            acc     <= 1'b0;
            lo      <= '0;
            hi      <= '0;
            carry   <= '0;
        end else begin
            done <= 1'b0;
            C_we <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    acc     <= acc_mode;
                    busy    <= 1'b1;
                    k       <= '0;
                    carry   <= '0;
                    C_raddr <= '0;
                    state   <= S_CRD;
                end
                S_CRD: begin
                    lo <= '0;
                    hi <= '0;
                    if (k == LAST_K) begin
                        state <= S_WR;
                    end else begin
                        i      <= i_lo;
                        A_addr <= i_lo;
                        B_addr <= k - i_lo;
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: state <= S_START;
                S_START: state <= S_WAIT;
                S_WAIT:  if (&mul_done) state <= S_ACC;
                S_ACC: begin
                    lo <= lo ^ fold_lo;
                    hi <= hi ^ fold_hi;
                    if (i == i_hi) begin
                        state <= S_WR;
                    end else begin
                        i      <= i_nxt;
                        A_addr <= i_nxt;
                        B_addr <= k - i_nxt;
                        state  <= S_ISSUE;
                    end
                end
                S_WR: begin
                    C_waddr <= k;
                    C_we    <= 1'b1;
                    C_do    <= lo ^ carry ^ (acc ? C_di : '0);
                    carry   <= hi;
                    if (k == LAST_K) begin
                        state <= S_DONE;
                    end else begin
                        k       <= k + 1'b1;
                        C_raddr <= k + 1'b1;
                        state   <= S_CRD;
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gf2mz_mul_engine.sv
// tb/tb_gf2mz_mul_engine.sv - vector table plus scoreboard bench for gf2mz_mul_engine
module tb_gf2mz_mul_engine;

    localparam int N       = 83;
    localparam int M       = 67;
    localparam int D       = 5;
    localparam int MUL_LAT = 6;
    localparam int WIDTH   = M * D;
    localparam int DEPTH   = (N + D - 1) / D;
    localparam int AW      = $clog2(2 * DEPTH);
    localparam int NP      = DEPTH * D;
    localparam int CWORDS  = 2 * DEPTH;
    localparam int LAT     = DEPTH * DEPTH * (MUL_LAT + 3) + 4 * DEPTH + 1;

    localparam logic [M-1:0] POLY_LOW = 'h27;
    localparam logic [M-1:0] ONE      = 'h1;
    localparam logic [M-1:0] XZ1      = 'h2;
    localparam logic [M-1:0] X66      = ONE << 66;

    logic             clk = 1'b0;
    logic             rst, start, acc_mode, busy, done, C_we;
    logic [AW-1:0]    A_addr, B_addr, C_raddr, C_waddr;
    logic [WIDTH-1:0] A_di, B_di, C_di, C_do;

    logic [WIDTH-1:0] a_mem [2**AW];
    logic [WIDTH-1:0] b_mem [2**AW];
    logic [WIDTH-1:0] c_mem [2**AW];
    logic [M-1:0]     ca [NP];
    logic [M-1:0]     cb [NP];
    logic [M-1:0]     cc [2*NP];
    logic [WIDTH-1:0] exp_q [$];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int           a0, a1;
        logic [M-1:0] av;
        int           b0, b1;
        logic [M-1:0] bv;
        logic         acc;
        logic         pre_ones;
        int           e0, e1;
        logic [M-1:0] ev;
        logic         e_ones;
    } vec_t;

    vec_t vecs [7];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        A_di <= a_mem[A_addr];
        B_di <= b_mem[B_addr];
        C_di <= c_mem[C_raddr];
    end

    gf2mz_mul_engine #(.N(N), .M(M), .D(D), .MUL_LAT(MUL_LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .acc_mode (acc_mode),
        .busy     (busy),
        .done     (done),
        .A_addr   (A_addr),
        .A_di     (A_di),
        .B_addr   (B_addr),
        .B_di     (B_di),
        .C_raddr  (C_raddr),
        .C_di     (C_di),
        .C_waddr  (C_waddr),
        .C_we     (C_we),
        .C_do     (C_do)
    );

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [2*M-2:0] t, ae, pe;
        t  = '0;
        ae = (2*M-1)'(a);
        pe = (2*M-1)'({1'b1, POLY_LOW});
        for (int n = 0; n < M; n++)
            if (b[n]) t = t ^ (ae << n);
        for (int n = 2*M-2; n >= M; n--)
            if (t[n]) t = t ^ (pe << (n - M));
        return t[M-1:0];
    endfunction

    function automatic logic [M-1:0] rnd_m();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[M-1:0];
    endfunction

    task automatic pack_ab();
        for (int w = 0; w < 2**AW; w++) begin
            a_mem[w] = '0;
            b_mem[w] = '0;
        end
        for (int w = 0; w < DEPTH; w++)
            for (int t = 0; t < D; t++) begin
                a_mem[w][(D-t)*M-1 -: M] = ca[w*D+t];
                b_mem[w][(D-t)*M-1 -: M] = cb[w*D+t];
            end
    endtask

    task automatic load_vec(input vec_t v);
        logic [WIDTH-1:0] word;
        logic [M-1:0]     ec;
        int               idx;
        for (int c = 0; c < NP; c++) begin
            ca[c] = '0;
            cb[c] = '0;
        end
        if (v.a0 >= 0) ca[v.a0] = v.av;
        if (v.a1 >= 0) ca[v.a1] = v.av;
        if (v.b0 >= 0) cb[v.b0] = v.bv;
        if (v.b1 >= 0) cb[v.b1] = v.bv;
        pack_ab();
        for (int w = 0; w < 2**AW; w++) c_mem[w] = v.pre_ones ? '1 : '0;
        for (int w = 0; w < CWORDS; w++) begin
            word = '0;
            for (int t = 0; t < D; t++) begin
                idx = w * D + t;
                ec  = (v.e_ones ? '1 : '0) ^ ((idx == v.e0 || idx == v.e1) ? v.ev : '0);
                word[(D-t)*M-1 -: M] = ec;
            end
            exp_q.push_back(word);
        end
    endtask

    task automatic load_random(input logic accm);
        for (int c = 0; c < NP; c++) begin
            ca[c] = (c < N) ? rnd_m() : '0;
            cb[c] = (c < N) ? rnd_m() : '0;
        end
        pack_ab();
        for (int w = 0; w < 2**AW; w++)
            for (int t = 0; t < D; t++) c_mem[w][(D-t)*M-1 -: M] = accm ? rnd_m() : '0;
    endtask

    task automatic push_model(input logic accm);
        logic [WIDTH-1:0] word;
        for (int c = 0; c < 2*NP; c++) cc[c] = '0;
        for (int x = 0; x < NP; x++)
            if (ca[x] != '0)
                for (int y = 0; y < NP; y++) cc[x+y] = cc[x+y] ^ gf_mul(ca[x], cb[y]);
        for (int w = 0; w < CWORDS; w++) begin
            word = accm ? c_mem[w] : '0;
            for (int t = 0; t < D; t++) word[(D-t)*M-1 -: M] ^= cc[w*D+t];
            exp_q.push_back(word);
        end
    endtask

    task automatic run_job(input logic accm, input int poke_at, input int rst_at);
        int cyc, nwr;
        bit fin;
        cyc = 0;
        nwr = 0;
        fin = 1'b0;
        @(negedge clk);
        start    = 1'b1;
        acc_mode = accm;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        acc_mode = ~accm;
        chk("busy_after_start", WIDTH'(busy), WIDTH'(1));
        while (!fin) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start = (cyc == poke_at);
            if (C_we) begin
                nwr++;
                if (exp_q.size() == 0) begin
                    chk("c_we_unexpected", WIDTH'(C_waddr), '1);
                end else begin
                    chk("c_do", C_do, exp_q.pop_front());
                    chk("c_waddr", WIDTH'(C_waddr), WIDTH'(nwr - 1));
                end
            end
            if (cyc == rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_c_we_drop", WIDTH'(C_we), '0);
                chk("rst_busy_drop", WIDTH'(busy), '0);
                repeat (2) @(negedge clk);
                chk("rst_hold_c_we", WIDTH'(C_we), '0);
                rst = 1'b0;
                exp_q.delete();
                fin = 1'b1;
            end else if (done) begin
                chk("latency", WIDTH'(cyc), WIDTH'(LAT));
                chk("write_count", WIDTH'(nwr), WIDTH'(CWORDS));
                chk("busy_at_done", WIDTH'(busy), '0);
                fin = 1'b1;
                @(negedge clk);
                chk("done_pulse", WIDTH'(done), '0);
            end else if (cyc > LAT + 20) begin
                chk("done_timeout", WIDTH'(cyc), WIDTH'(LAT));
                fin = 1'b1;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        vecs[0] = '{a0:0,  a1:-1, av:ONE, b0:82, b1:-1, bv:ONE, acc:1'b0, pre_ones:1'b0, e0:82, e1:-1, ev:ONE,      e_ones:1'b0};
        vecs[1] = '{a0:0,  a1:1,  av:ONE, b0:0,  b1:1,  bv:ONE, acc:1'b0, pre_ones:1'b0, e0:0,  e1:2,  ev:ONE,      e_ones:1'b0};
        vecs[2] = '{a0:4,  a1:-1, av:ONE, b0:4,  b1:-1, bv:ONE, acc:1'b0, pre_ones:1'b0, e0:8,  e1:-1, ev:ONE,      e_ones:1'b0};
        vecs[3] = '{a0:-1, a1:-1, av:ONE, b0:-1, b1:-1, bv:ONE, acc:1'b1, pre_ones:1'b1, e0:-1, e1:-1, ev:ONE,      e_ones:1'b1};
        vecs[4] = '{a0:-1, a1:-1, av:ONE, b0:-1, b1:-1, bv:ONE, acc:1'b0, pre_ones:1'b1, e0:-1, e1:-1, ev:ONE,      e_ones:1'b0};
        vecs[5] = '{a0:3,  a1:-1, av:X66, b0:7,  b1:-1, bv:XZ1, acc:1'b0, pre_ones:1'b0, e0:10, e1:-1, ev:POLY_LOW, e_ones:1'b0};
        vecs[6] = '{a0:0,  a1:-1, av:ONE, b0:0,  b1:-1, bv:ONE, acc:1'b1, pre_ones:1'b1, e0:0,  e1:-1, ev:ONE,      e_ones:1'b1};

        for (int w = 0; w < 2**AW; w++) begin
            a_mem[w] = '0;
            b_mem[w] = '0;
            c_mem[w] = '0;
        end
        rst      = 1'b1;
        start    = 1'b0;
        acc_mode = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy",    WIDTH'(busy),    '0);
        chk("reset_done",    WIDTH'(done),    '0);
        chk("reset_c_we",    WIDTH'(C_we),    '0);
        chk("reset_a_addr",  WIDTH'(A_addr),  '0);
        chk("reset_b_addr",  WIDTH'(B_addr),  '0);
        chk("reset_c_raddr", WIDTH'(C_raddr), '0);
        chk("reset_c_waddr", WIDTH'(C_waddr), '0);
        chk("reset_c_do",    C_do,            '0);
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            load_vec(vecs[v]);
            run_job(vecs[v].acc, -1, -1);
        end

        // Back-to-back random jobs, each with a stray start pulse mid-job.
        for (int r = 0; r < 6; r++) begin
            logic accm;
            accm = r[0];
            load_random(accm);
            push_model(accm);
            run_job(accm, 300 + 250 * r, -1);
        end

        load_random(1'b0);
        push_model(1'b0);
        run_job(1'b0, -1, 1000);
        push_model(1'b0);
        run_job(1'b0, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
